// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory byte writer.
package instr_mem_pkg;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte lane k of a big-endian word: lane 0 is [31:24], lane 3 is [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    unique case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instr_mem_byte_writer_byte_ram.sv
// Byte-wide RAM: one synchronous write port, four asynchronous read ports.
module byte_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [7:0]                         wdata,
  input  logic [instr_mem_pkg::BYTES_PER_WORD-1:0][ADDR_W-1:0] raddr,
  output logic [instr_mem_pkg::BYTES_PER_WORD-1:0][7:0]        rdata
);
  import instr_mem_pkg::*;

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      rdata[i] = r_mem[raddr[i]];
    end
  end

endmodule

// File: rtl/instr_mem_byte_writer.sv
// Accepts 32-bit word writes and commits them big-endian, one byte per clock;
// exposes a combinational big-endian word read port over the same RAM.
module instr_mem_byte_writer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        busy,
  output logic        done,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data
);
  import instr_mem_pkg::*;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_k;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_data;
  logic [3:0]          r_be;
  logic                r_done;

  logic                w_accept;
  logic                w_we;
  logic                w_last;
  logic [ADDR_W-1:0]   w_waddr;
  logic [7:0]          w_wdata;
  logic [ADDR_W-1:0]   w_rbase;
  logic [BYTES_PER_WORD-1:0][ADDR_W-1:0] w_raddr;
  logic [BYTES_PER_WORD-1:0][7:0]        w_rbytes;
  logic                w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_we        = 1'b0;
    w_last      = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        wr_ready = !rst;
        w_accept = wr_valid && !rst;
        if (w_accept) begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        // Reset on this edge abandons the sequence before the lane is committed.
        w_we = r_be[2'd3 - r_k] && !rst;
        if (r_k == 2'd3) begin
          w_state_nxt = IDLE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_accept) begin
        r_base <= wr_addr[ADDR_W-1:0];
        r_data <= wr_data;
        r_be   <= wr_be;
        r_k    <= '0;
      end else if (r_state == WRITE) begin
        r_k <= r_k + 2'd1;
      end
    end
  end

  assign done    = r_done;
  assign w_waddr = r_base + ADDR_W'(r_k);
  assign w_wdata = lane_byte(r_data, r_k);
  assign w_rbase = rd_addr[ADDR_W-1:0];

  always_comb begin
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      w_raddr[i] = w_rbase + ADDR_W'(i);
    end
  end

  assign rd_data  = {w_rbytes[0], w_rbytes[1], w_rbytes[2], w_rbytes[3]};
  assign w_unused = ^{wr_addr[31:ADDR_W], rd_addr[31:ADDR_W]};

  byte_ram #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(w_wdata),
    .raddr(w_raddr),
    .rdata(w_rbytes)
  );

endmodule

// File: tb/tb_instr_mem_byte_writer.sv
// Directed bench for instr_mem_byte_writer with a timeline-based reference model.
module tb_instr_mem_byte_writer;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        busy;
  logic        done;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  instr_mem_byte_writer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes a list of timed byte writes;
  // ready/busy/done follow from when the block is next free.
  typedef struct { int t; int a; logic [7:0] d; } bw_t;
  bw_t        sched[$];
  logic [7:0] m_mem[DEPTH];
  bit         m_known[DEPTH];
  int         cyc = -1;
  int         free_at = 1 << 30;
  int         done_at = -1;
  bit         armed = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sched.delete();
      done_at = -1;
      free_at = cyc;
      armed   = 1;
    end else if (armed) begin
      while (sched.size() > 0 && sched[0].t == cyc) begin
        m_mem[sched[0].a]   = sched[0].d;
        m_known[sched[0].a] = 1;
        void'(sched.pop_front());
      end
      if (wr_valid && (cyc - 1) >= free_at) begin
        for (int ln = 0; ln < 4; ln++) begin
          logic [31:0] sh;
          bw_t w;
          sh = wr_data >> (24 - 8 * ln);
          w.t = cyc + 1 + ln;
          w.a = (int'(wr_addr[AW-1:0]) + ln) % DEPTH;
          w.d = sh[7:0];
          if (wr_be[3-ln]) sched.push_back(w);
        end
        free_at = cyc + 4;
        done_at = cyc + 4;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (armed) begin
      int a;
      bit kn;
      logic [31:0] exp_rd;
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, (!rst && cyc >= free_at)});
      chk("busy", {31'd0, busy}, {31'd0, (cyc < free_at)});
      chk("done", {31'd0, done}, {31'd0, (cyc == done_at)});
      a  = int'(rd_addr[AW-1:0]);
      kn = 1;
      exp_rd = '0;
      for (int i = 0; i < 4; i++) begin
        kn = kn && m_known[(a + i) % DEPTH];
        exp_rd = (exp_rd << 8) | {24'd0, m_mem[(a + i) % DEPTH]};
      end
      if (kn) chk("rd_data_model", rd_data, exp_rd);
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    wr_addr = a; wr_data = d; wr_be = be; wr_valid = 1'b1;
    n = 0;
    #1;
    while (!wr_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_ready", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    while (lat < 12) begin
      #1;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    chk(name, lat, 32'd4);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    issue(a, d, be);
    wait_done("done_edges_after_accept");
  endtask

  initial begin
    int cnt;
    int seen;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", {31'd0, wr_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, wr_ready}, 32'd1);

    write_word(32'h014, 32'h55667788, 4'b1111);
    write_word(32'h010, 32'hDEADBEEF, 4'b1111);
    rd_chk("rd_010", 32'h010, 32'hDEADBEEF);
    rd_chk("rd_011", 32'h011, 32'hADBEEF55);

    write_word(32'h010, 32'h00000000, 4'b0000);
    rd_chk("be0_unchanged", 32'h010, 32'hDEADBEEF);

    write_word(32'h020, 32'h11223344, 4'b1111);
    write_word(32'h020, 32'hAABBCCDD, 4'b1010);
    rd_chk("partial_be", 32'h020, 32'hAA22CC44);

    write_word(32'h000, 32'h99AABBCC, 4'b1111);
    write_word(32'h3FE, 32'h01020304, 4'b1111);
    rd_chk("wrap_3fe", 32'h3FE, 32'h01020304);
    rd_chk("wrap_3ff", 32'h3FF, 32'h020304BB);
    rd_chk("wrap_000", 32'h000, 32'h0304BBCC);

    // Back-to-back with wr_valid held
    @(negedge clk);
    issue(32'h0, 32'hCAFEF00D, 4'b1111);
    wr_addr = 32'h4; wr_data = 32'h12345678; wr_valid = 1'b1;
    cnt = 0;
    while (cnt < 12) begin
      #1;
      if (wr_ready) break;
      cnt++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles_1", cnt, 32'd4);
    chk("b2b_done_at_accept", {31'd0, done}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    cnt = 0;
    while (cnt < 12) begin
      #1;
      if (wr_ready) break;
      cnt++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles_2", cnt, 32'd4);
    chk("b2b_done_2", {31'd0, done}, 32'd1);
    rd_chk("b2b_rd_0", 32'h0, 32'hCAFEF00D);
    rd_chk("b2b_rd_4", 32'h4, 32'h12345678);

    // Reset mid-sequence
    write_word(32'h040, 32'h00000000, 4'b1111);
    write_word(32'h100, 32'h0BADF00D, 4'b1111);
    @(negedge clk);
    issue(32'h040, 32'hA1B2C3D4, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("ready_after_midreset", {31'd0, wr_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (done) seen++;
    end
    chk("no_done_after_reset", seen, 32'd0);
    rd_chk("torn_by_reset", 32'h040, 32'hA1B20000);
    rd_chk("valid_in_reset_ignored", 32'h100, 32'h0BADF00D);

    // Upper address bits ignored
    @(negedge clk);
    write_word(32'hFFFF_F008, 32'h5A5AA5A5, 4'b1111);
    rd_chk("alias_008", 32'h008, 32'h5A5AA5A5);
    rd_chk("alias_rd_upper", 32'h7777_7008, 32'h5A5AA5A5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
